// File: rtl/ps2_frame_rx_if.sv
// Scan-code output bundle of the PS/2 frame receiver; the master drives a received
// byte with its valid pulse and a frame-error pulse, the slave (decoder FIFO) observes them.
interface ps2_frame_rx_if;
  logic [7:0] kbdcode;
  logic       kbdcodeValid;
  logic       frameError;

  modport master (output kbdcode, kbdcodeValid, frameError);
  modport slave  (input  kbdcode, kbdcodeValid, frameError);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock de-glitch filter,
// 11-bit frame deserializer with odd-parity/stop checking and a stalled-frame watchdog.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               KBD_CLK,
  input  logic               KBD_DATA,
  ps2_frame_rx_if.master     code_if
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic                  fclk_prev_q, fclk_prev_d;
  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [7:0]            code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic bit_strobe;
  logic bit_val;
  logic timeout;

  // Front end: two-flop synchronizers, then the filtered clock only moves once
  // every stage of the shift register agrees, which swallows short glitches.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], KBD_CLK};
    data_sync_d = {data_sync_q[0], KBD_DATA};
    filt_d      = {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
    fclk_prev_d = fclk_q;
    fclk_d      = fclk_q;
    if (&filt_q) begin
      fclk_d = 1'b1;
    end else if (~|filt_q) begin
      fclk_d = 1'b0;
    end
  end

  assign bit_strobe = fclk_prev_q & ~fclk_q;
  assign bit_val    = data_sync_q[1];

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    wd_d     = wd_q;

    if (bit_strobe || (state_q == ST_IDLE)) begin
      wd_d = '0;
    end else if (wd_q != WD_LAST) begin
      wd_d = wd_q + 1'b1;
    end

    // A strobe in the same cycle as the limit is still a live frame, so it wins.
    timeout = (state_q != ST_IDLE) && !bit_strobe && (wd_q == WD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (bit_strobe && !bit_val) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_strobe) begin
          shift_d = {bit_val, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (bit_strobe) begin
          parity_d = bit_val;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_strobe) begin
          if (bit_val && (^{shift_q, parity_q})) begin
            code_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      shift_d = 8'h00;
      err_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= '1;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      code_q      <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  assign code_if.kbdcode      = code_q;
  assign code_if.kbdcodeValid = valid_q;
  assign code_if.frameError   = err_q;

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host frame receiver. It synchronizes and de-glitches the raw `KBD_CLK`/`KBD_DATA` pins and deserializes 11-bit frames (start, 8 data bits LSB first, odd parity, stop). It emits each good scan-code byte as a one-cycle pulse and runs a watchdog that discards stalled frames. It sits directly upstream of the keyboard scan-code decoder: its `kbdcode`/`kbdcodeValid` drive the decoder's scan-code FIFO push.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical samples required before the filtered PS/2 clock changes state (min 2).
- `TIMEOUT_CYCLES`, default 27000: idle-strobe limit inside a frame, in `clk` cycles (1 ms at 27 MHz).

Ports:
- `clk`  in  1: system clock; the only clock.
- `resetn`  in  1: reset, asynchronous, active-low.
- `KBD_CLK`  in  1: raw PS/2 clock pin, asynchronous.
- `KBD_DATA`  in  1: raw PS/2 data pin, asynchronous.
- `kbdcode`  out  8: last correctly received byte.
- `kbdcodeValid`  out  1: one-cycle pulse; `kbdcode` is new this cycle.
- `frameError`  out  1: one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
- Synchronizers: two flops each on `KBD_CLK` and `KBD_DATA`. Reset value is 1.
- Clock filter:
  - `FILTER_LEN`-deep shift register of synchronized `KBD_CLK`.
  - `fclk` goes to 0 when all stages are 0 and to 1 when all are 1; otherwise it holds. Reset value is 1.
- Strobe: `fclk` 1->0 transition (registered previous value) gives a one-cycle `bitStrobe`. The data bit is the synchronized `KBD_DATA` in the strobe cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with bit=0 goes to DATA with bit counter=0. Strobe with bit=1 is ignored (stays IDLE, no error).
  - DATA: on each strobe the bit is shifted into shift[7] and the register shifts right, so the LSB arrives first. The counter increments; after the 8th bit the FSM goes to PARITY.
  - PARITY: on strobe, latch the parity bit and go to STOP.
  - STOP: on strobe, a frame is good when bit=1 and XOR(shift[7:0], parity)=1.
    - Good frame: `kbdcode`<=shift and `kbdcodeValid`=1.
    - Otherwise: `frameError`=1 and `kbdcode` is unchanged.
    - Either way the FSM goes to IDLE.
- Watchdog:
  - Counter clears on every `bitStrobe` and while in IDLE, and increments otherwise.
  - On reaching `TIMEOUT_CYCLES-1` outside IDLE: go to IDLE, pulse `frameError`, discard the partial byte.
  - The counter saturates, so it never wraps.
- Host-to-device transmission and clock inhibit are not supported; the pins are inputs only.

## Timing
- Reset values:
  - `kbdcode`=0x00, `kbdcodeValid`=0, `frameError`=0.
  - FSM=IDLE, counters=0.
  - Synchronizers, filter and `fclk`=1.
- Pin-to-strobe latency: 2 sync cycles + `FILTER_LEN` filter cycles + 1 edge-detect cycle after `KBD_CLK` falls.
- `kbdcodeValid`/`frameError` are registered and assert the cycle after the STOP-state strobe. They are never both high and are never high for more than 1 cycle.
- `kbdcode` changes only in the `kbdcodeValid` cycle and holds until the next good frame.
- Back-to-back frames: an IDLE strobe in the cycle after STOP completion is accepted as a start bit.
- Glitches shorter than `FILTER_LEN` cycles on `KBD_CLK` produce no strobe.
- Timeout and strobe in the same cycle: the strobe wins and the counter clears.
- `resetn` low mid-frame: all state returns to reset values asynchronously; no pulse is emitted.

## Test plan
- Clean frame for byte 0x1C (data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> one `kbdcodeValid` pulse, `kbdcode`=0x1C, `frameError` stays 0.
- Same frame with parity 1 -> one `frameError` pulse, no valid pulse, `kbdcode` retains its previous value.
- Frame for 0x1C with stop=0 -> `frameError` pulse; a following clean 0x5A frame -> valid pulse with `kbdcode`=0x5A.
- Back-to-back frames 0xF0 then 0x1C with minimum gap -> two valid pulses, values 0xF0 then 0x1C in order.
- 1-cycle and (`FILTER_LEN`-1)-cycle low glitches on `KBD_CLK` mid-frame, then completion of a 0x29 frame -> valid pulse with `kbdcode`=0x29, no error.
- Error and reset recovery:
  - Stimulus: start bit plus 5 data bits, then no clock for `TIMEOUT_CYCLES` cycles.
  - Response: `frameError` pulse and FSM back in IDLE.
  - Then: assert `resetn` mid-frame -> outputs at reset values; next clean 0x76 frame is received correctly.
